// File: rtl/sdhci_sdma_engine.sv
// SDMA engine: moves whole SD blocks between the data buffer and system memory, pausing at buffer boundaries.
// Optional macro SDHCI_SDMA_ALIGN_CHECK_EN: misaligned address loads raise an error instead of being truncated.
module sdhci_sdma_engine #(
    parameter int AddrWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 dir_read_i,
    input  logic [AddrWidth-1:0] sys_addr_i,
    input  logic                 sys_addr_we_i,
    input  logic [2:0]           boundary_i,
    input  logic [11:0]          block_size_i,
    input  logic [15:0]          block_count_i,
    input  logic                 multi_block_i,
    input  logic                 buf_rd_ready_i,
    output logic                 buf_rd_o,
    input  logic [31:0]          buf_rdata_i,
    input  logic                 buf_wr_ready_i,
    output logic                 buf_wr_o,
    output logic [31:0]          buf_wdata_o,
    output logic                 mem_req_o,
    input  logic                 mem_gnt_i,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic                 mem_we_o,
    output logic [3:0]           mem_be_o,
    output logic [31:0]          mem_wdata_o,
    input  logic                 mem_rvalid_i,
    input  logic [31:0]          mem_rdata_i,
    input  logic                 mem_err_i,
    output logic [AddrWidth-1:0] sys_addr_o,
    output logic                 busy_o,
    output logic                 dma_int_o,
    output logic                 done_o,
    output logic                 dma_err_o
);

    typedef enum logic [2:0] {IDLE, WAIT_BUF, MEM_REQ, MEM_RSP, PAUSE, ERROR} state_e;

    state_e               state_q;
    logic                 dir_q;
    logic                 blk_start_q;
    logic                 abort_pend_q;
    logic [2:0]           boundary_q;
    logic [11:0]          block_size_q;
    logic [10:0]          words_left_q;
    logic [15:0]          blocks_left_q;
    logic [AddrWidth-1:0] sys_addr_q;

    logic [15:0]          eff_count;
    logic [3:0]           last_be;
    logic [19:0]          bnd_mask;
    logic [AddrWidth-1:0] addr_next;
    logic [AddrWidth-1:0] load_addr;
    logic                 load_fault;
    logic                 last_word;
    logic                 last_block;
    logic                 at_boundary;
    logic                 start_ok;
    logic                 pop_now;
    logic                 issue_now;

    function automatic logic [10:0] words_of(input logic [11:0] size);
        return {1'b0, size[11:2]} + {10'd0, |size[1:0]};
    endfunction

`ifdef SDHCI_SDMA_ALIGN_CHECK_EN
    assign load_addr  = sys_addr_i;
    assign load_fault = |sys_addr_i[1:0];
`else
    assign load_addr  = sys_addr_i & ~AddrWidth'(3);
    assign load_fault = 1'b0;
`endif

    assign eff_count   = multi_block_i ? block_count_i : 16'd1;
    assign addr_next   = sys_addr_q + AddrWidth'(4);
    assign bnd_mask    = (20'h01000 << boundary_q) - 20'd1;
    assign at_boundary = (addr_next[19:0] & bnd_mask) == 20'd0;
    assign last_word   = words_left_q == 11'd1;
    assign last_block  = blocks_left_q == 16'd1;
    assign start_ok    = start_i && !abort_i && (state_q == IDLE || state_q == ERROR);

    // buf_rd_o doubles as the "word being popped" phase: the data is captured while it is high.
    assign pop_now   = state_q == WAIT_BUF && dir_q && !buf_rd_o && (!blk_start_q || buf_rd_ready_i);
    assign issue_now = state_q == WAIT_BUF && (dir_q ? buf_rd_o : (!blk_start_q || buf_wr_ready_i));

    always_comb begin
        unique case (block_size_q[1:0])
            2'd1:    last_be = 4'h1;
            2'd2:    last_be = 4'h3;
            2'd3:    last_be = 4'h7;
            default: last_be = 4'hF;
        endcase
    end

    // NOTE: the buffer push must coincide with the memory response, so this path is combinational.
    assign buf_wr_o    = state_q == MEM_RSP && mem_rvalid_i && !mem_err_i && !dir_q
                         && !abort_pend_q && !abort_i;
    assign buf_wdata_o = buf_wr_o ? mem_rdata_i : 32'd0;
    assign sys_addr_o  = sys_addr_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            dir_q         <= 1'b0;
            blk_start_q   <= 1'b0;
            abort_pend_q  <= 1'b0;
            boundary_q    <= 3'd0;
            block_size_q  <= 12'd0;
            words_left_q  <= 11'd0;
            blocks_left_q <= 16'd0;
            sys_addr_q    <= '0;
            buf_rd_o      <= 1'b0;
            mem_req_o     <= 1'b0;
            mem_addr_o    <= '0;
            mem_we_o      <= 1'b0;
            mem_be_o      <= 4'h0;
            mem_wdata_o   <= 32'd0;
            busy_o        <= 1'b0;
            dma_int_o     <= 1'b0;
            done_o        <= 1'b0;
            dma_err_o     <= 1'b0;
        end else begin
            done_o    <= 1'b0;
            dma_int_o <= 1'b0;
            dma_err_o <= 1'b0;
            buf_rd_o  <= 1'b0;
            if (abort_i && state_q != MEM_RSP) begin
                state_q   <= IDLE;
                busy_o    <= 1'b0;
                mem_req_o <= 1'b0;
            end else if (start_ok) begin
                dir_q         <= dir_read_i;
                boundary_q    <= boundary_i;
                block_size_q  <= block_size_i;
                words_left_q  <= words_of(block_size_i);
                blocks_left_q <= eff_count;
                sys_addr_q    <= load_addr;
                blk_start_q   <= 1'b1;
                abort_pend_q  <= 1'b0;
                if (load_fault) begin
                    dma_err_o <= 1'b1;
                    busy_o    <= 1'b1;
                    state_q   <= ERROR;
                end else if (block_size_i == 12'd0 || eff_count == 16'd0) begin
                    done_o  <= 1'b1;
                    busy_o  <= 1'b0;
                    state_q <= IDLE;
                end else begin
                    busy_o  <= 1'b1;
                    state_q <= WAIT_BUF;
                end
            end else begin
                case (state_q)
                    IDLE: if (sys_addr_we_i) sys_addr_q <= load_addr;
                    WAIT_BUF: begin
                        buf_rd_o <= pop_now;
                        if (issue_now) begin
                            if (dir_q) mem_wdata_o <= buf_rdata_i;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= dir_q;
                            mem_addr_o  <= sys_addr_q & ~AddrWidth'(3);
                            mem_be_o    <= last_word ? last_be : 4'hF;
                            blk_start_q <= 1'b0;
                            state_q     <= MEM_REQ;
                        end
                    end
                    MEM_REQ: if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        state_q   <= MEM_RSP;
                    end
                    MEM_RSP: begin
                        if (mem_rvalid_i) begin
                            if (abort_pend_q || abort_i) begin
                                abort_pend_q <= 1'b0;
                                busy_o       <= 1'b0;
                                state_q      <= IDLE;
                            end else if (mem_err_i) begin
                                dma_err_o <= 1'b1;
                                state_q   <= ERROR;
                            end else begin
                                sys_addr_q <= addr_next;
                                if (last_word) begin
                                    words_left_q  <= words_of(block_size_q);
                                    blocks_left_q <= blocks_left_q - 16'd1;
                                    blk_start_q   <= 1'b1;
                                end else begin
                                    words_left_q <= words_left_q - 11'd1;
                                end
                                if (last_word && last_block) begin
                                    done_o  <= 1'b1;
                                    busy_o  <= 1'b0;
                                    state_q <= IDLE;
                                end else if (at_boundary) begin
                                    dma_int_o <= 1'b1;
                                    state_q   <= PAUSE;
                                end else begin
                                    state_q <= WAIT_BUF;
                                end
                            end
                        end else if (abort_i) begin
                            abort_pend_q <= 1'b1;
                        end
                    end
                    PAUSE: if (sys_addr_we_i) begin
                        sys_addr_q <= load_addr;
                        if (load_fault) begin
                            dma_err_o <= 1'b1;
                            state_q   <= ERROR;
                        end else begin
                            state_q <= WAIT_BUF;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdhci_sdma_engine.sv
// Self-checking bench for sdhci_sdma_engine: table of complete transfers plus hand-written pause,
// buffer-hold, bus-error, abort, alignment and reset sequences against a simple memory/buffer model.
module tb_sdhci_sdma_engine;

    logic        clk_i;
    logic        rst_ni;
    logic        start_i, abort_i, dir_read_i, sys_addr_we_i, multi_block_i;
    logic [31:0] sys_addr_i;
    logic [2:0]  boundary_i;
    logic [11:0] block_size_i;
    logic [15:0] block_count_i;
    logic        buf_rd_ready_i, buf_rd_o, buf_wr_ready_i, buf_wr_o;
    logic [31:0] buf_rdata_i, buf_wdata_o;
    logic        mem_req_o, mem_gnt_i, mem_we_o, mem_rvalid_i, mem_err_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i, sys_addr_o;
    logic [3:0]  mem_be_o;
    logic        busy_o, dma_int_o, done_o, dma_err_o;

    sdhci_sdma_engine #(.AddrWidth(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
        .dir_read_i(dir_read_i), .sys_addr_i(sys_addr_i), .sys_addr_we_i(sys_addr_we_i),
        .boundary_i(boundary_i), .block_size_i(block_size_i), .block_count_i(block_count_i),
        .multi_block_i(multi_block_i), .buf_rd_ready_i(buf_rd_ready_i), .buf_rd_o(buf_rd_o),
        .buf_rdata_i(buf_rdata_i), .buf_wr_ready_i(buf_wr_ready_i), .buf_wr_o(buf_wr_o),
        .buf_wdata_o(buf_wdata_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
        .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .mem_err_i(mem_err_i), .sys_addr_o(sys_addr_o), .busy_o(busy_o),
        .dma_int_o(dma_int_o), .done_o(done_o), .dma_err_o(dma_err_o)
    );

    typedef struct {
        logic        dir;
        logic [31:0] addr;
        logic [2:0]  bnd;
        logic [11:0] size;
        logic [15:0] cnt;
        logic        multi;
        int          wpb;
        int          words;
        logic [3:0]  last_be;
        logic [31:0] final_addr;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // Memory/buffer model state, owned by the responder process.
    int          done_cnt = 0, int_cnt = 0, err_cnt = 0, rd_pops = 0, req_cycles = 0, rsp_idx = 0;
    int          err_at = -1;
    bit          hold_gnt = 1'b0;
    bit          rsp_pending = 1'b0;
    logic [31:0] rsp_addr;
    logic [31:0] txn_addr[$];
    logic [3:0]  txn_be[$];
    logic        txn_we[$];
    logic [31:0] txn_wdata[$];
    logic [31:0] wr_q[$];

    function automatic logic [31:0] buf_pat(input int n);
        return 32'hB000_0000 + 32'(n);
    endfunction

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return a ^ 32'hC3C3_0000;
    endfunction

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
        mem_rdata_i = 32'd0; buf_rdata_i = buf_pat(0);
        forever begin
            @(negedge clk_i);
            mem_rvalid_i = 1'b0;
            mem_err_i    = 1'b0;
            if (rsp_pending) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_fn(rsp_addr);
                mem_err_i    = (rsp_idx == err_at);
                rsp_idx++;
                rsp_pending  = 1'b0;
            end
            buf_rdata_i = buf_pat(rd_pops);
            if (buf_rd_o) rd_pops++;
            mem_gnt_i = mem_req_o && !hold_gnt;
            if (mem_gnt_i) begin
                txn_addr.push_back(mem_addr_o);
                txn_be.push_back(mem_be_o);
                txn_we.push_back(mem_we_o);
                txn_wdata.push_back(mem_wdata_o);
                rsp_addr    = mem_addr_o;
                rsp_pending = 1'b1;
            end
            #1;
            if (buf_wr_o) wr_q.push_back(buf_wdata_o);
            if (done_o) done_cnt++;
            if (dma_int_o) int_cnt++;
            if (dma_err_o) err_cnt++;
            if (mem_req_o) req_cycles++;
        end
    end

    task automatic tick();
        @(negedge clk_i);
        #3;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        txn_addr.delete(); txn_be.delete(); txn_we.delete(); txn_wdata.delete(); wr_q.delete();
    endtask

    task automatic start_xfer(input logic dir, input logic [31:0] addr, input logic [2:0] bnd,
                              input logic [11:0] size, input logic [15:0] cnt, input logic multi);
        dir_read_i = dir; sys_addr_i = addr; boundary_i = bnd;
        block_size_i = size; block_count_i = cnt; multi_block_i = multi;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic wait_idle(input int d0, input int budget);
        for (int c = 0; c < budget; c++) begin
            if (done_cnt != d0 && !busy_o) break;
            tick();
        end
    endtask

    task automatic run_vec(input int vi, input vec_t v);
        int          base, d0, i0, e0;
        logic [31:0] a;
        logic [3:0]  be;
        clear_logs();
        base = rd_pops; d0 = done_cnt; i0 = int_cnt; e0 = err_cnt;
        start_xfer(v.dir, v.addr, v.bnd, v.size, v.cnt, v.multi);
        wait_idle(d0, 3000);
        tick();
        check($sformatf("v%0d_ntxn", vi), txn_addr.size(), v.words);
        if (!v.dir) check($sformatf("v%0d_nbufwr", vi), wr_q.size(), v.words);
        for (int k = 0; k < v.words && k < txn_addr.size(); k++) begin
            a  = v.addr + 32'(4 * k);
            be = ((k % v.wpb) == v.wpb - 1) ? v.last_be : 4'hF;
            check($sformatf("v%0d_addr%0d", vi, k), txn_addr[k], a);
            check($sformatf("v%0d_be%0d", vi, k), txn_be[k], be);
            check($sformatf("v%0d_we%0d", vi, k), txn_we[k], v.dir);
            if (v.dir) check($sformatf("v%0d_wdata%0d", vi, k), txn_wdata[k], buf_pat(base + k));
            else if (k < wr_q.size()) check($sformatf("v%0d_bufw%0d", vi, k), wr_q[k], mem_fn(a));
        end
        check($sformatf("v%0d_done", vi), done_cnt - d0, 1);
        check($sformatf("v%0d_int", vi), int_cnt - i0, 0);
        check($sformatf("v%0d_err", vi), err_cnt - e0, 0);
        check($sformatf("v%0d_busy", vi), busy_o, 0);
        check($sformatf("v%0d_sysaddr", vi), sys_addr_o, v.final_addr);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {buf_rd_o, buf_wr_o, mem_req_o, mem_we_o, busy_o, dma_int_o,
                              done_o, dma_err_o, mem_be_o}, 0);
        check({tag, "_memaddr"}, mem_addr_o, 0);
        check({tag, "_sysaddr"}, sys_addr_o, 0);
        check({tag, "_data"}, {mem_wdata_o, buf_wdata_o}, 0);
    endtask

    vec_t vecs[9];

    initial begin
        int base, d0, i0, e0, r0, p0;

        vecs[0] = '{1'b1, 32'h0000_1000, 3'd0, 12'd512, 16'd1, 1'b1, 128, 128, 4'hF, 32'h0000_1200};
        vecs[1] = '{1'b1, 32'h0000_2000, 3'd0, 12'd6,   16'd2, 1'b1, 2,   4,   4'h3, 32'h0000_2010};
        vecs[2] = '{1'b0, 32'h0000_3000, 3'd0, 12'd8,   16'd3, 1'b0, 2,   2,   4'hF, 32'h0000_3008};
        vecs[3] = '{1'b0, 32'h0000_4010, 3'd0, 12'd7,   16'd2, 1'b1, 2,   4,   4'h7, 32'h0000_4020};
        vecs[4] = '{1'b1, 32'h0000_5000, 3'd0, 12'd0,   16'd5, 1'b1, 1,   0,   4'hF, 32'h0000_5000};
        vecs[5] = '{1'b1, 32'h0000_5100, 3'd0, 12'd4,   16'd0, 1'b1, 1,   0,   4'hF, 32'h0000_5100};
        vecs[6] = '{1'b1, 32'h0000_0FF8, 3'd0, 12'd8,   16'd1, 1'b1, 2,   2,   4'hF, 32'h0000_1000};
        vecs[7] = '{1'b0, 32'h0000_0FF8, 3'd1, 12'd16,  16'd1, 1'b1, 4,   4,   4'hF, 32'h0000_1008};
        vecs[8] = '{1'b1, 32'hFFFF_FFF8, 3'd7, 12'd5,   16'd1, 1'b1, 2,   2,   4'h1, 32'h0000_0000};

        rst_ni = 1'b1; start_i = 1'b0; abort_i = 1'b0; dir_read_i = 1'b0; sys_addr_we_i = 1'b0;
        multi_block_i = 1'b0; sys_addr_i = 32'd0; boundary_i = 3'd0; block_size_i = 12'd0;
        block_count_i = 16'd0; buf_rd_ready_i = 1'b1; buf_wr_ready_i = 1'b1;
        #2 rst_ni = 1'b0;
        #1 check_all_zero("rst");
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();
        check_all_zero("idle");

        sys_addr_i = 32'h0000_1234; sys_addr_we_i = 1'b1;
        tick();
        sys_addr_we_i = 1'b0;
        check("idle_addr_we", sys_addr_o, 32'h0000_1234);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Boundary pause and software resume.
        clear_logs();
        d0 = done_cnt; i0 = int_cnt;
        start_xfer(1'b0, 32'h0000_0FF8, 3'd0, 12'd16, 16'd1, 1'b1);
        for (int c = 0; c < 200; c++) begin
            if (int_cnt != i0) break;
            tick();
        end
        check("pause_int", int_cnt - i0, 1);
        check("pause_addr", sys_addr_o, 32'h0000_1000);
        check("pause_ntxn", txn_addr.size(), 2);
        r0 = req_cycles;
        repeat (10) tick();
        check("pause_noreq", req_cycles - r0, 0);
        check("pause_busy", busy_o, 1);
        sys_addr_i = 32'h0000_8000; sys_addr_we_i = 1'b1;
        tick();
        sys_addr_we_i = 1'b0;
        wait_idle(d0, 200);
        tick();
        check("resume_ntxn", txn_addr.size(), 4);
        if (txn_addr.size() == 4) begin
            check("resume_addr2", txn_addr[2], 32'h0000_8000);
            check("resume_addr3", txn_addr[3], 32'h0000_8004);
        end
        check("resume_nbufwr", wr_q.size(), 4);
        if (wr_q.size() == 4) check("resume_bufw3", wr_q[3], mem_fn(32'h0000_8004));
        check("resume_done", done_cnt - d0, 1);
        check("resume_int", int_cnt - i0, 1);
        check("resume_sysaddr", sys_addr_o, 32'h0000_8008);

        // Buffer not ready before the second block.
        clear_logs();
        base = rd_pops; d0 = done_cnt;
        start_xfer(1'b1, 32'h0000_2000, 3'd0, 12'd6, 16'd2, 1'b1);
        for (int c = 0; c < 50; c++) begin
            if (rd_pops - base >= 2) break;
            tick();
        end
        buf_rd_ready_i = 1'b0;
        repeat (6) tick();
        p0 = rd_pops; r0 = req_cycles;
        repeat (10) tick();
        check("hold_nopop", rd_pops - p0, 0);
        check("hold_noreq", req_cycles - r0, 0);
        check("hold_ntxn", txn_addr.size(), 2);
        buf_rd_ready_i = 1'b1;
        wait_idle(d0, 200);
        tick();
        check("hold_total", txn_addr.size(), 4);
        if (txn_addr.size() == 4) begin
            check("hold_be", {txn_be[0], txn_be[1], txn_be[2], txn_be[3]}, 16'hF3F3);
            check("hold_wdata3", txn_wdata[3], buf_pat(base + 3));
        end
        check("hold_done", done_cnt - d0, 1);

        // Bus error on the third response.
        clear_logs();
        d0 = done_cnt; e0 = err_cnt;
        err_at = rsp_idx + 2;
        start_xfer(1'b1, 32'h0000_1000, 3'd0, 12'd512, 16'd1, 1'b1);
        for (int c = 0; c < 100; c++) begin
            if (err_cnt != e0) break;
            tick();
        end
        repeat (5) tick();
        check("err_pulse", err_cnt - e0, 1);
        check("err_nodone", done_cnt - d0, 0);
        check("err_busy", busy_o, 1);
        check("err_ntxn", txn_addr.size(), 3);
        check("err_sysaddr", sys_addr_o, 32'h0000_1008);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        err_at = -1;
        check("err_abort_busy", busy_o, 0);
        tick();

        // Abort while the request is waiting for a grant.
        clear_logs();
        hold_gnt = 1'b1;
        d0 = done_cnt;
        start_xfer(1'b1, 32'h0000_1000, 3'd0, 12'd16, 16'd1, 1'b1);
        for (int c = 0; c < 20; c++) begin
            if (mem_req_o) break;
            tick();
        end
        check("abt_req_seen", mem_req_o, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("abt_req_drop", mem_req_o, 0);
        check("abt_busy", busy_o, 0);
        check("abt_nodone", done_cnt - d0, 0);
        hold_gnt = 1'b0;
        tick();
        run_vec(20, vecs[1]);

        // Misaligned start address.
        clear_logs();
        d0 = done_cnt; e0 = err_cnt; p0 = rd_pops;
        start_xfer(1'b1, 32'h0000_1002, 3'd0, 12'd4, 16'd1, 1'b1);
`ifdef SDHCI_SDMA_ALIGN_CHECK_EN
        repeat (10) tick();
        check("align_err", err_cnt - e0, 1);
        check("align_ntxn", txn_addr.size(), 0);
        check("align_nopop", rd_pops - p0, 0);
        check("align_busy", busy_o, 1);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("align_abort_busy", busy_o, 0);
`else
        wait_idle(d0, 100);
        tick();
        check("align_ntxn", txn_addr.size(), 1);
        if (txn_addr.size() == 1) check("align_addr", txn_addr[0], 32'h0000_1000);
        check("align_noerr", err_cnt - e0, 0);
        check("align_sysaddr", sys_addr_o, 32'h0000_1004);
`endif

        // Asynchronous reset in the middle of a transfer.
        clear_logs();
        start_xfer(1'b1, 32'h0000_1000, 3'd0, 12'd512, 16'd1, 1'b1);
        repeat (21) tick();
        check("midrst_busy_before", busy_o, 1);
        rst_ni = 1'b0;
        #1 check_all_zero("midrst");
        tick();
        rst_ni = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
